multiport_regfile: RTL and testbench

- Parametrised general-purpose register file for the pipelined and multicore datapath.
- Provides NRD combinational read ports and NWR write ports, with register 0 hardwired to zero.
- Includes a per-register pending-write scoreboard for hazard detection.
- Includes a sequential sweep clear used on context flush.
- Replaces the fixed 2R1W negedge-write register file; all state updates on posedge CLK.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/multiport_regfile.sv | 133 +++++++++++++
 tb/tb_multiport_regfile.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared register-file types and sweep FSM state encoding
// Rev 1.0
// ============================================================================
package cpu_types_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_NREGS  = 32;
  localparam int c_AW     = $clog2(c_NREGS);

  typedef logic [c_AW-1:0]     regbits_t;
  typedef logic [c_DATA_W-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// rf_scoreboard : per-register pending-write bits with registered popcount
// Rev 1.0
// ============================================================================
module rf_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             set_en,
  input  logic [AW-1:0]    set_sel,
  input  logic [NREGS-1:0] clr_mask,
  output logic [NREGS-1:0] pending,
  output logic [AW:0]      pend_cnt
);

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_nxt;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_cnt_nxt;

  // Set is applied after clear so an issuing producer wins over a retiring one.
  always_comb begin
    w_pend_nxt = r_pend & ~clr_mask;
    if (set_en && (set_sel != '0)) w_pend_nxt[set_sel] = 1'b1;
    w_pend_nxt[0] = 1'b0;
    w_cnt_nxt = '0;
    for (int i = 1; i < NREGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_pend_nxt[i]};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign pending  = r_pend;
  assign pend_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/multiport_regfile.sv
`default_nettype none
// ============================================================================
// multiport_regfile : NRD-read / NWR-write register file, r0 hardwired to zero,
//   pending scoreboard and sweep clear. Forwarding option: MULTIPORT_REGFILE_BYPASS_EN
// Rev 1.0
// ============================================================================
module multiport_regfile
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NRD*AW-1:0]     rsel,
  output logic [NRD*DATA_W-1:0] rdat,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*AW-1:0]     wsel,
  input  logic [NWR*DATA_W-1:0] wdat,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_sel,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic [AW:0]           pend_cnt
);

  rf_state_t        r_state;
  rf_state_t        w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] w_pending;
  logic             w_sweep;

  assign w_sweep  = (r_state == SWEEP);
  assign clr_busy = w_sweep;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clr_req) w_state_nxt = SWEEP;
      SWEEP:   if (r_ptr == AW'(NREGS-1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && clr_req) r_ptr <= AW'(1);
      else if (w_sweep)               r_ptr <= r_ptr + AW'(1);
    end
  end

  // Later ports overwrite earlier ones in the loop, giving highest-index-wins.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_sweep) begin
      r_regs[r_ptr] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && (wsel[j*AW +: AW] != '0))
          r_regs[wsel[j*AW +: AW]] <= wdat[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_clr_mask = '0;
    if (w_sweep) begin
      w_clr_mask[r_ptr] = 1'b1;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && (wsel[j*AW +: AW] != '0)) w_clr_mask[wsel[j*AW +: AW]] = 1'b1;
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .CLK      (CLK),
    .nRST     (nRST),
    .set_en   (iss_en && !w_sweep),
    .set_sel  (iss_sel),
    .clr_mask (w_clr_mask),
    .pending  (w_pending),
    .pend_cnt (pend_cnt)
  );

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]     w_sel;
      logic [DATA_W-1:0] w_data;
      logic              w_busy;

      assign w_sel = rsel[k*AW +: AW];

      always_comb begin
        w_data = r_regs[w_sel];
        w_busy = w_pending[w_sel];
        if (w_sel == '0) begin
          w_data = '0;
          w_busy = 1'b0;
        end
`ifdef MULTIPORT_REGFILE_BYPASS_EN
        if (!w_sweep && (w_sel != '0)) begin
          for (int j = 0; j < NWR; j++) begin
            if (wen[j] && (wsel[j*AW +: AW] == w_sel)) begin
              w_data = wdat[j*DATA_W +: DATA_W];
              w_busy = 1'b0;
            end
          end
        end
`endif
      end

      assign rdat[k*DATA_W +: DATA_W] = w_data;
      assign rbusy[k]                 = w_busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multiport_regfile.sv
`default_nettype none
// ============================================================================
// tb_multiport_regfile : scoreboard bench for default and 16x64 / 4R1W builds
// Rev 1.0
// ============================================================================
module tb_multiport_regfile;

  localparam int AW  = 5;
  localparam int AW1 = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic nRST;

  logic [2*AW-1:0] rsel;
  logic [63:0]     rdat;
  logic [1:0]      rbusy;
  logic [1:0]      wen;
  logic [2*AW-1:0] wsel;
  logic [63:0]     wdat;
  logic            iss_en;
  logic [AW-1:0]   iss_sel;
  logic            clr_req;
  logic            clr_busy;
  logic [AW:0]     pend_cnt;

  logic [4*AW1-1:0] rsel1;
  logic [255:0]     rdat1;
  logic [3:0]       rbusy1;
  logic [0:0]       wen1;
  logic [AW1-1:0]   wsel1;
  logic [63:0]      wdat1;
  logic             iss_en1;
  logic [AW1-1:0]   iss_sel1;
  logic             clr_req1;
  logic             clr_busy1;
  logic [AW1:0]     pend_cnt1;

  multiport_regfile u_dut (
    .CLK(CLK), .nRST(nRST), .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
    .wen(wen), .wsel(wsel), .wdat(wdat), .iss_en(iss_en), .iss_sel(iss_sel),
    .clr_req(clr_req), .clr_busy(clr_busy), .pend_cnt(pend_cnt)
  );

  multiport_regfile #(.DATA_W(64), .NREGS(16), .NRD(4), .NWR(1)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .rsel(rsel1), .rdat(rdat1), .rbusy(rbusy1),
    .wen(wen1), .wsel(wsel1), .wdat(wdat1), .iss_en(iss_en1), .iss_sel(iss_sel1),
    .clr_req(clr_req1), .clr_busy(clr_busy1), .pend_cnt(pend_cnt1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  string       tagq[$];
  logic [63:0] expq[$];
  logic [63:0] m1 [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    tagq.push_back(tag);
    expq.push_back(exp);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    if (expq.size() == 0) chk("sb_underflow", 64'(expq.size()), 64'd1);
    else chk(tagq.pop_front(), obs, expq.pop_front());
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr0(input logic [AW-1:0] sel, input logic [31:0] data);
    wen  = 2'b01;
    wsel = {{AW{1'b0}}, sel};
    wdat = {32'd0, data};
  endtask

  task automatic rd_chk(input string tag, input int port, input logic [AW-1:0] sel,
                        input logic [31:0] exp);
    rsel[port*AW +: AW] = sel;
    #1;
    sb_push(tag, 64'(exp));
    sb_pop(64'(rdat[port*32 +: 32]));
  endtask

  task automatic sb_check_now(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    sb_push(tag, exp);
    sb_pop(obs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] e;
    nRST = 1'b0;
    rsel = {5'd5, 5'd5}; wen = '0; wsel = '0; wdat = '0;
    iss_en = 1'b0; iss_sel = '0; clr_req = 1'b0;
    rsel1 = '0; wen1 = '0; wsel1 = '0; wdat1 = '0;
    iss_en1 = 1'b0; iss_sel1 = '0; clr_req1 = 1'b0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    #2;
    sb_push("rst_rdat0", 64'd0);
    sb_push("rst_rdat1", 64'd0);
    sb_push("rst_rbusy", 64'd0);
    sb_push("rst_pend", 64'd0);
    sb_push("rst_clrbusy", 64'd0);
    sb_pop(64'(rdat[31:0]));
    sb_pop(64'(rdat[63:32]));
    sb_pop(64'(rbusy));
    sb_pop(64'(pend_cnt));
    sb_pop(64'(clr_busy));
    #10 nRST = 1'b1;
    step();

    // r0 is never writable
    wr0(5'd0, 32'hDEADBEEF);
    step();
    wen = '0;
    rd_chk("r0_read", 0, 5'd0, 32'd0);

    // dual write to reg 7, port 1 must win
    wen = 2'b11; wsel = {5'd7, 5'd7}; wdat = {32'h22222222, 32'h11111111};
    step();
    wen = '0;
    rd_chk("dual_wr", 0, 5'd7, 32'h22222222);

    // scoreboard set, clear, then set/clear collision
    iss_en = 1'b1; iss_sel = 5'd3;
    step();
    iss_en = 1'b0;
    rsel = {5'd3, 5'd0};
    #1;
    sb_check_now("iss_rbusy", 64'(rbusy[1]), 64'd1);
    sb_check_now("iss_pend", 64'(pend_cnt), 64'd1);
    wr0(5'd3, 32'h0000ABCD);
    step();
    wen = '0;
    #1;
    sb_check_now("wr_rbusy", 64'(rbusy[1]), 64'd0);
    sb_check_now("wr_pend", 64'(pend_cnt), 64'd0);
    sb_check_now("wr_data", 64'(rdat[63:32]), 64'h0000ABCD);
    wr0(5'd3, 32'h77); iss_en = 1'b1; iss_sel = 5'd3;
    step();
    wen = '0; iss_en = 1'b0;
    #1;
    sb_check_now("coll_rbusy", 64'(rbusy[1]), 64'd1);
    sb_check_now("coll_pend", 64'(pend_cnt), 64'd1);

    // fill then sweep
    for (int i = 1; i < 32; i++) begin
      wr0(AW'(i), 32'(i));
      step();
    end
    wen = '0;
    iss_en = 1'b1; iss_sel = 5'd10;
    step();
    iss_en = 1'b0;
    rd_chk("fill_r1", 0, 5'd1, 32'd1);
    rd_chk("fill_r31", 1, 5'd31, 32'd31);
    sb_check_now("pre_sweep_pend", 64'(pend_cnt), 64'd1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      if (n == 3) clr_req = 1'b1;
      if (n == 4) clr_req = 1'b0;
      if (n == 25) begin
        wr0(5'd2, 32'h999); iss_en = 1'b1; iss_sel = 5'd2;
      end
      if (n == 26) begin
        wen = '0; iss_en = 1'b0;
      end
      n++;
      step();
    end
    wen = '0; iss_en = 1'b0; clr_req = 1'b0;
    sb_check_now("sweep_len", 64'(n), 64'd31);
    sb_check_now("post_sweep_pend", 64'(pend_cnt), 64'd0);
    for (int i = 1; i < 32; i++) begin
      rd_chk("sweep_rd", i % 2, AW'(i), 32'd0);
      step();
    end
    rsel = {5'd0, 5'd2};
    #1;
    sb_check_now("sweep_rbusy", 64'(rbusy[0]), 64'd0);
    step();

    // reset in the middle of a sweep
    wen = 2'b11; wsel = {5'd31, 5'd4}; wdat = {32'h31, 32'h44};
    step();
    wen = '0; iss_en = 1'b1; iss_sel = 5'd6;
    step();
    iss_en = 1'b0;
    #1;
    sb_check_now("pre_rst_pend", 64'(pend_cnt), 64'd1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    nRST = 1'b0;
    #1;
    sb_check_now("rst_mid_clrbusy", 64'(clr_busy), 64'd0);
    sb_check_now("rst_mid_pend", 64'(pend_cnt), 64'd0);
    rsel = {5'd31, 5'd4};
    #1;
    sb_check_now("rst_mid_r4", 64'(rdat[31:0]), 64'd0);
    sb_check_now("rst_mid_r31", 64'(rdat[63:32]), 64'd0);
    rsel = {5'd31, 5'd6};
    #1;
    sb_check_now("rst_mid_rbusy", 64'(rbusy[0]), 64'd0);
    step();
    nRST = 1'b1;
    step();
    sb_check_now("rst_mid_idle", 64'(clr_busy), 64'd0);

    // write-then-read timing / forwarding
    wr0(5'd9, 32'h1234);
    step();
    wen = '0;
    wr0(5'd9, 32'h55AA);
    rsel = {5'd9, 5'd0};
    #1;
`ifdef MULTIPORT_REGFILE_BYPASS_EN
    sb_check_now("same_cycle_rd", 64'(rdat[63:32]), 64'h55AA);
`else
    sb_check_now("same_cycle_rd", 64'(rdat[63:32]), 64'h1234);
`endif
    step();
    wen = '0;
    #1;
    sb_check_now("next_cycle_rd", 64'(rdat[63:32]), 64'h55AA);

    // 16 x 64-bit, 4R1W instance against a reference array
    step();
    for (int c = 0; c < 60; c++) begin
      wen1  = 1'($urandom_range(0, 1));
      wsel1 = AW1'($urandom_range(0, 15));
      wdat1 = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) rsel1[k*AW1 +: AW1] = AW1'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < 4; k++) begin
        e = (rsel1[k*AW1 +: AW1] == '0) ? 64'd0 : m1[rsel1[k*AW1 +: AW1]];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
        if (wen1[0] && wsel1 == rsel1[k*AW1 +: AW1] && wsel1 != '0) e = wdat1;
`endif
        sb_push("rand_rd", e);
      end
      for (int k = 0; k < 4; k++) sb_pop(rdat1[k*64 +: 64]);
      if (wen1[0] && wsel1 != '0) m1[wsel1] = wdat1;
      step();
    end
    wen1 = '0;
    clr_req1 = 1'b1;
    step();
    clr_req1 = 1'b0;
    n = 0;
    while (clr_busy1 === 1'b1 && n < 100) begin
      n++;
      step();
    end
    sb_check_now("sweep16_len", 64'(n), 64'd15);
    for (int i = 1; i < 16; i++) begin
      rsel1[AW1-1:0] = AW1'(i);
      #1;
      sb_check_now("sweep16_rd", rdat1[63:0], 64'd0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
